// File: rtl/cdb_if.sv
// Result-bus bundle between three execution units, the ROB stall line and the
// common data bus arbiter. master = unit/ROB side, slave = arbiter side.
interface cdb_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int ROB_W  = 2
);
  logic              add_req,   mul_req,   ld_req;
  logic [TAG_W-1:0]  add_tag,   mul_tag,   ld_tag;
  logic [DATA_W-1:0] add_data,  mul_data,  ld_data;
  logic [ROB_W-1:0]  add_rob,   mul_rob,   ld_rob;
  logic              stall;
  logic              add_grant, mul_grant, ld_grant;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_id;
  logic [DATA_W-1:0] cdb_data;
  logic [ROB_W-1:0]  cdb_rob;

  modport master (
    output add_req, mul_req, ld_req, add_tag, mul_tag, ld_tag,
           add_data, mul_data, ld_data, add_rob, mul_rob, ld_rob, stall,
    input  add_grant, mul_grant, ld_grant, cdb_valid, cdb_id, cdb_data, cdb_rob
  );

  modport slave (
    input  add_req, mul_req, ld_req, add_tag, mul_tag, ld_tag,
           add_data, mul_data, ld_data, add_rob, mul_rob, ld_rob, stall,
    output add_grant, mul_grant, ld_grant, cdb_valid, cdb_id, cdb_data, cdb_rob
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for add/mul/ld results onto a single registered CDB.
// Grants are combinational; the broadcast appears exactly one cycle later.
module cdb_arbiter #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int ROB_W  = 2
) (
  input logic   clk,
  input logic   rst_n,
  cdb_if.slave  bus
);
  localparam int NUM_REQ = 3;

  logic [NUM_REQ-1:0]             req_a, elig;
  logic [NUM_REQ-1:0][TAG_W-1:0]  tag_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_a;
  logic [NUM_REQ-1:0][ROB_W-1:0]  rob_a;

  assign req_a  = {bus.ld_req,  bus.mul_req,  bus.add_req};
  assign tag_a  = {bus.ld_tag,  bus.mul_tag,  bus.add_tag};
  assign data_a = {bus.ld_data, bus.mul_data, bus.add_data};
  assign rob_a  = {bus.ld_rob,  bus.mul_rob,  bus.add_rob};

  // Tag 0 means "no tag": such a request is never eligible.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign elig[i] = req_a[i] && (tag_a[i] != '0);
  end

  logic [1:0]        ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ROB_W-1:0]  rob_q, rob_d;

  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         win, idx;
  logic [2:0]         sum;
  logic               found;

  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    // Scan from the pointer, wrapping mod 3; first eligible requester wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    gnt = '0;
    if (found && !bus.stall && rst_n) gnt = 3'(3'b001 << win);

    ptr_d = ptr_q;
    if (|gnt) ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;

    valid_d = |gnt;
    id_d    = '0;
    data_d  = '0;
    rob_d   = '0;
    if (|gnt) begin
      id_d   = tag_a[win];
      data_d = data_a[win];
      rob_d  = rob_a[win];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      rob_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
      rob_q   <= rob_d;
    end
  end

  assign bus.add_grant = gnt[0];
  assign bus.mul_grant = gnt[1];
  assign bus.ld_grant  = gnt[2];
  assign bus.cdb_valid = valid_q;
  assign bus.cdb_id    = id_q;
  assign bus.cdb_data  = data_q;
  assign bus.cdb_rob   = rob_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued at grant time
// and popped when the CDB should carry them one cycle later.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdb_if #(.DATA_W(64), .TAG_W(4), .ROB_W(2)) bus();
  cdb_arbiter #(.DATA_W(64), .TAG_W(4), .ROB_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] rob; } exp_t;
  exp_t exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic r, input logic [3:0] t,
                       input logic [63:0] d, input logic [1:0] rb);
    case (u)
      0: begin bus.add_req = r; bus.add_tag = t; bus.add_data = d; bus.add_rob = rb; end
      1: begin bus.mul_req = r; bus.mul_tag = t; bus.mul_data = d; bus.mul_rob = rb; end
      default: begin bus.ld_req = r; bus.ld_tag = t; bus.ld_data = d; bus.ld_rob = rb; end
    endcase
  endtask

  task automatic idle_all();
    for (int u = 0; u < 3; u++) drive(u, 1'b0, 4'd0, 64'd0, 2'd0);
  endtask

  task automatic chk_cdb_zero(input string nm);
    chk({nm, "_valid"}, 64'(bus.cdb_valid), 64'd0);
    chk({nm, "_id"},    64'(bus.cdb_id),    64'd0);
    chk({nm, "_data"},  bus.cdb_data,       64'd0);
    chk({nm, "_rob"},   64'(bus.cdb_rob),   64'd0);
  endtask

  // One arbitration cycle: check grants mid-cycle, then the CDB just after the edge.
  task automatic cycle(input logic [2:0] eg, input string nm);
    exp_t e;
    #1;
    chk({nm, "_gnt"}, 64'({bus.ld_grant, bus.mul_grant, bus.add_grant}), 64'(eg));
    if (eg == 3'b001) begin e.id = bus.add_tag; e.data = bus.add_data; e.rob = bus.add_rob; exp_q.push_back(e); end
    if (eg == 3'b010) begin e.id = bus.mul_tag; e.data = bus.mul_data; e.rob = bus.mul_rob; exp_q.push_back(e); end
    if (eg == 3'b100) begin e.id = bus.ld_tag;  e.data = bus.ld_data;  e.rob = bus.ld_rob;  exp_q.push_back(e); end
    @(posedge clk);
    #1;
    if (eg != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk({nm, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk({nm, "_valid"}, 64'(bus.cdb_valid), 64'd1);
        chk({nm, "_id"},    64'(bus.cdb_id),    64'(e.id));
        chk({nm, "_data"},  bus.cdb_data,       e.data);
        chk({nm, "_rob"},   64'(bus.cdb_rob),   64'(e.rob));
      end
    end else begin
      chk_cdb_zero(nm);
    end
  endtask

  initial begin
    idle_all();
    bus.stall = 1'b0;
    // Reset: outputs and grants zero even with a request present and clock running.
    drive(0, 1'b1, 4'd1, 64'h9, 2'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'({bus.ld_grant, bus.mul_grant, bus.add_grant}), 64'd0);
    chk_cdb_zero("rst");
    idle_all();
    rst_n = 1'b1;

    // Single add request, then an idle cycle clears the bus.
    drive(0, 1'b1, 4'd1, 64'h5, 2'd2);
    cycle(3'b001, "single_add");
    idle_all();
    cycle(3'b000, "single_idle");

    // Pointer is at mul; one ld grant brings it back to add.
    drive(2, 1'b1, 4'd3, 64'h33, 2'd1);
    cycle(3'b100, "ld_realign");

    // All three continuously: strict rotation add, mul, ld, add.
    drive(0, 1'b1, 4'd1, 64'hA1, 2'd0);
    drive(1, 1'b1, 4'd4, 64'hB4, 2'd1);
    drive(2, 1'b1, 4'd6, 64'hC6, 2'd3);
    cycle(3'b001, "rr0_add");
    cycle(3'b010, "rr1_mul");
    cycle(3'b100, "rr2_ld");
    cycle(3'b001, "rr3_add");
    idle_all();

    // mul with tag 0 is ignored; ld tag 7 wins, then mul alone stays ungranted.
    drive(1, 1'b1, 4'd0, 64'hDEAD, 2'd1);
    drive(2, 1'b1, 4'd7, 64'h77, 2'd2);
    cycle(3'b100, "notag_ld");
    drive(2, 1'b0, 4'd0, 64'd0, 2'd0);
    cycle(3'b000, "notag_mul_alone");
    idle_all();

    // Stall for three cycles with add and ld pending, pointer at add.
    drive(0, 1'b1, 4'd2, 64'h22, 2'd0);
    drive(2, 1'b1, 4'd9, 64'h99, 2'd3);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) cycle(3'b000, "stall");
    bus.stall = 1'b0;
    cycle(3'b001, "unstall_add");
    drive(0, 1'b0, 4'd0, 64'd0, 2'd0);
    cycle(3'b100, "unstall_ld");
    idle_all();

    // mul grant moves pointer to ld; add+mul pending wraps to add, then mul.
    drive(1, 1'b1, 4'd5, 64'h55, 2'd1);
    cycle(3'b010, "wrap_mul_first");
    drive(0, 1'b1, 4'd8, 64'h88, 2'd2);
    cycle(3'b001, "wrap_add");
    drive(0, 1'b0, 4'd0, 64'd0, 2'd0);
    cycle(3'b010, "wrap_mul");
    idle_all();

    // Leave pointer at ld with a broadcast in flight, then reset asynchronously.
    drive(1, 1'b1, 4'd5, 64'h1234, 2'd3);
    cycle(3'b010, "pre_rst_mul");
    drive(2, 1'b1, 4'd7, 64'h4321, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 64'({bus.ld_grant, bus.mul_grant, bus.add_grant}), 64'd0);
    chk_cdb_zero("async_rst");
    @(posedge clk);
    #1;
    chk_cdb_zero("rst_held");
    rst_n = 1'b1;
    // Pointer restarts at add, so mul beats ld; no replay of the lost result.
    cycle(3'b010, "post_rst_mul");
    drive(1, 1'b0, 4'd0, 64'd0, 2'd0);
    cycle(3'b100, "post_rst_ld");
    idle_all();
    cycle(3'b000, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of result data.
REQ-002 SHALL have parameter TAG_W, default 4, width of RS tag / CDB id (0 = notag).
REQ-003 SHALL have parameter ROB_W, default 2, width of ROB slot index.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports add_req / mul_req / ld_req  in  1 each  unit result pending.
REQ-007 SHALL have ports add_tag / mul_tag / ld_tag  in  TAG_W each  producing RS tag.
REQ-008 SHALL have ports add_data / mul_data / ld_data  in  DATA_W each  result value.
REQ-009 SHALL have ports add_rob / mul_rob / ld_rob  in  ROB_W each  destination ROB slot.
REQ-010 SHALL have port stall  in  1  ROB cannot accept a write this cycle.
REQ-011 SHALL have ports add_grant / mul_grant / ld_grant  out  1 each  request accepted this cycle.
REQ-012 SHALL have port cdb_valid  out  1  broadcast valid.
REQ-013 SHALL have port cdb_id  out  TAG_W  broadcast tag.
REQ-014 SHALL have port cdb_data  out  DATA_W  broadcast value.
REQ-015 SHALL have port cdb_rob  out  ROB_W  broadcast ROB slot.

Function
REQ-016 A request SHALL be eligible only when its req=1 and its tag != 0; req with tag 0 SHALL be ignored and never granted.
REQ-017 At most one grant SHALL be high per cycle; grants SHALL be combinational from eligible requests, pointer and stall.
REQ-018 Selection SHALL be round-robin, order add(0) -> mul(1) -> ld(2); the first eligible requester at or after the pointer SHALL win.
REQ-019 After a grant to requester i, the pointer SHALL become (i+1) mod 3 at the next edge; with no grant the pointer SHALL hold.
REQ-020 When stall=1, all grants SHALL be 0 and the pointer SHALL hold.
REQ-021 A grant in cycle N SHALL register the winner's tag/data/rob onto cdb_id/cdb_data/cdb_rob with cdb_valid=1 in cycle N+1 only; latency is exactly 1 cycle.
REQ-022 In any cycle following a cycle with no grant, cdb_valid=0, cdb_id=0, cdb_data=0 and cdb_rob=0.
REQ-023 Back-to-back grants SHALL produce back-to-back broadcasts: one result per cycle throughput.
REQ-024 Requesters SHALL hold req and payload stable until granted; the arbiter SHALL sample the payload only in the grant cycle.
REQ-025 A requester whose grant is seen SHALL be treated as a new request if req stays high next cycle, and SHALL not be re-granted ahead of other eligible requesters.
REQ-026 With all three eligible continuously, grants SHALL rotate so no requester waits more than 2 cycles between grants, with stall low.

Reset
REQ-027 While rst_n=0: pointer=0 (add), cdb_valid=0, cdb_id=0, cdb_data=0, cdb_rob=0, all grants 0, regardless of clk.
REQ-028 Assertion mid-broadcast SHALL drop cdb_valid immediately; the in-flight result SHALL be lost, with no replay after release.
REQ-029 First edge after rst_n rises SHALL arbitrate normally from pointer=0.

Verification
REQ-030 Reset, then add_req=1 tag=1 data=0x5 rob=2 alone -> add_grant=1 same cycle; next cycle cdb_valid=1 id=1 data=0x5 rob=2; following cycle all CDB outputs 0.
REQ-031 All three req high continuously, tags 1/4/6 -> grants add,mul,ld,add,... ; cdb_id sequence 1,4,6,1 on consecutive cycles.
REQ-032 mul_req with tag=0 plus ld_req tag=7 -> only ld_grant; mul never granted; cdb_id=7.
REQ-033 stall=1 for 3 cycles with add and ld pending -> no grants, cdb_valid=0, pointer held; stall=0 -> add granted first.
REQ-034 rst_n pulled low asynchronously while cdb_valid=1 -> outputs 0 before next edge; after release, pending mul (tag 5) granted from pointer=0 order.
REQ-035 Pointer=2 (after mul grant), only add and mul pending -> add granted, wrap-around verified.
